muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit sitting directly downstream of the register file. It consumes the two read-port operands (rs1/rs2 data) and produces a 32-bit result for the write-back path.
- The core stalls while busy_o is high.
- The core writes result_o to the register file in the cycle done_o pulses.
- Radix-2 shift-add multiply and restoring divide: one bit per cycle.

---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/muldiv_unit.sv | 197 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

  // RV32M funct3 encoding of the M-extension ops.
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  // Divide and remainder ops occupy the upper half of the encoding.
  function automatic logic is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  // Operand A (rs1) is treated as two's complement.
  function automatic logic a_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Operand B (rs2) is treated as two's complement.
  function automatic logic b_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, one bit per cycle, with the sign
// applied on the final iteration. Divide-by-zero and signed overflow bypass
// the iteration and finish two cycles after accept.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNTW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // Architectural state.
  muldiv_state_e   r_state;
  muldiv_op_e      r_op;
  logic [XLEN-1:0] r_a;       // |A|: multiplicand
  logic [XLEN-1:0] r_b;       // |B|: divisor
  logic [XLEN-1:0] r_acc;     // product high half / partial remainder / special result
  logic [XLEN-1:0] r_shf;     // multiplier bits out, or dividend bits out / quotient bits in
  logic [CNTW-1:0] r_cnt;
  logic            r_neg_a;
  logic            r_neg_b;
  logic            r_spec;    // special-case result parked in r_acc, not yet published
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  // Accept-time decode of the request.
  muldiv_op_e      w_op;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_spec_val;

  assign w_op    = muldiv_op_e'(op_i);
  assign w_neg_a = a_signed(w_op) & rs1_i[XLEN-1];
  assign w_neg_b = b_signed(w_op) & rs2_i[XLEN-1];
  // Negating the most-negative value yields 2^(XLEN-1), which is exactly
  // its magnitude when read as unsigned.
  assign w_mag_a = w_neg_a ? -rs1_i : rs1_i;
  assign w_mag_b = w_neg_b ? -rs2_i : rs2_i;
  assign w_div0  = is_div(w_op) && (rs2_i == '0);
  assign w_ovf   = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                   (rs1_i == MOST_NEG) && (rs2_i == '1);

  // Special-case results: divide by zero, then signed overflow.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_spec_val = '0;
    if (w_div0) begin
      w_spec_val = ((w_op == OP_DIV) || (w_op == OP_DIVU)) ? '1 : rs1_i;
    end else if (w_ovf) begin
      w_spec_val = (w_op == OP_DIV) ? MOST_NEG : '0;
    end
  end

  // One multiply step: conditionally add, then shift {acc, shf} right.
  logic [XLEN:0]   w_sum;
  logic [XLEN-1:0] w_mul_acc;
  logic [XLEN-1:0] w_mul_shf;

  assign w_sum     = {1'b0, r_acc} + {1'b0, r_a};
  assign w_mul_acc = r_shf[0] ? w_sum[XLEN:1] : {1'b0, r_acc[XLEN-1:1]};
  assign w_mul_shf = {(r_shf[0] ? w_sum[0] : r_acc[0]), r_shf[XLEN-1:1]};

  // One restoring-divide step: shift in the next dividend bit, trial subtract.
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN-1:0] w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_div_acc;
  logic [XLEN-1:0] w_div_shf;

  assign w_rem_sh  = {r_acc, r_shf[XLEN-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_b});
  // When the subtraction is kept the true difference is below |B|, so the
  // low XLEN bits are exact.
  assign w_diff    = w_rem_sh[XLEN-1:0] - r_b;
  assign w_div_acc = w_ge ? w_diff : w_rem_sh[XLEN-1:0];
  assign w_div_shf = {r_shf[XLEN-2:0], w_ge};

  // Next datapath values; shared registers serve both algorithms.
  logic [XLEN-1:0]   w_acc_n;
  logic [XLEN-1:0]   w_shf_n;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_final;

  assign w_acc_n    = is_div(r_op) ? w_div_acc : w_mul_acc;
  assign w_shf_n    = is_div(r_op) ? w_div_shf : w_mul_shf;
  assign w_prod     = {w_acc_n, w_shf_n};
  assign w_prod_fix = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
  assign w_quo      = (r_neg_a ^ r_neg_b) ? -w_shf_n : w_shf_n;
  assign w_rem      = r_neg_a ? -w_acc_n : w_acc_n;

  // Sign-corrected result selection for the final iteration.
  always_comb begin
    w_final = w_prod_fix[XLEN-1:0];
    case (r_op)
      OP_MUL:                       w_final = w_prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_final = w_quo;
      default:                      w_final = w_rem;
    endcase
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk_i) begin
    // NOTE: datapath registers are reset along with control so an aborted
    // operation leaves nothing stale behind; sequential state uses <= only.
    if (rst_i) begin
      r_state  <= IDLE;
      r_op     <= OP_MUL;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_shf    <= '0;
      r_cnt    <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_spec   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_op    <= w_op;
            r_a     <= w_mag_a;
            r_b     <= w_mag_b;
            r_neg_a <= w_neg_a;
            r_neg_b <= w_neg_b;
            r_cnt   <= CNTW'(XLEN);
            r_busy  <= 1'b1;
            if (w_div0 || w_ovf) begin
              r_acc   <= w_spec_val;
              r_shf   <= '0;
              r_spec  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_acc   <= '0;
              r_shf   <= is_div(w_op) ? w_mag_a : w_mag_b;
              r_state <= CALC;
            end
          end
        end

        CALC: begin
          r_acc <= w_acc_n;
          r_shf <= w_shf_n;
          r_cnt <= r_cnt - CNTW'(1);
          if (r_cnt == CNTW'(1)) begin
            r_result <= w_final;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end
        end

        DONE: begin
          if (r_spec) begin
            // Special case publishes its parked result one cycle after entry.
            r_result <= r_acc;
            r_done   <= 1'b1;
            r_spec   <= 1'b0;
          end else begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign result_o = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver pushes expected results and
// completion cycles, a negedge monitor pops and compares on every done_o.
module tb_muldiv_unit;

  localparam int LAT_NORM = 33;
  localparam int LAT_SPEC = 2;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural rules.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int              ia, ib;
    longint          sa, sbv;
    longint unsigned ua, ub;
    logic [63:0]     p;
    ia = a; ib = b;
    sa = ia; sbv = ib;
    ua = {32'b0, a}; ub = {32'b0, b};
    case (op)
      3'd0: begin p = ua * ub;           return p[31:0];  end
      3'd1: begin p = sa * sbv;          return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub;           return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sbv; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub;  return p[31:0]; end
      3'd6: begin if (b == 0) return a;             p = sa % sbv; return p[31:0]; end
      default: begin if (b == 0) return a;          p = ua % ub;  return p[31:0]; end
    endcase
  endfunction

  function automatic int latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 3'd4 && b == 0) return LAT_SPEC;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return LAT_SPEC;
    return LAT_NORM;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done_o pulse must match the oldest outstanding request.
  always @(negedge clk_i) begin
    if (!rst_i && done_o) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done_o=1 expected no pending request (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result_o, e.res);
        check("done_cycle", cyc, e.done_cyc);
        check("busy_at_done", 32'(busy_o), 32'd1);
      end
    end
  end

  // Called on a negedge; returns on the first negedge where the unit is idle.
  task automatic wait_idle();
    int n = 0;
    while ((busy_o || done_o) && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy_o=%b expected 0 within 100 cycles", busy_o);
    end
  endtask

  // Drive one request from a negedge; the following posedge accepts it.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int exp_lat, input bit push);
    exp_t e;
    wait_idle();
    op_i = op; rs1_i = a; rs2_i = b; start_i = 1'b1;
    if (push) begin
      e.res = exp_res;
      e.done_cyc = cyc + exp_lat;
      sb.push_back(e);
    end
    @(negedge clk_i);
    start_i = 1'b0;
    op_i = 3'($urandom_range(0, 7));
    rs1_i = $urandom;
    rs2_i = $urandom;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t dir[11];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected completion before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    dir[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_NORM};
    dir[1]  = '{3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, LAT_NORM};
    dir[2]  = '{3'd3, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, LAT_NORM};
    dir[3]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, LAT_NORM};
    dir[4]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, LAT_NORM};
    dir[5]  = '{3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, LAT_NORM};
    dir[6]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_NORM};
    dir[7]  = '{3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, LAT_SPEC};
    dir[8]  = '{3'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, LAT_SPEC};
    dir[9]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPEC};
    dir[10] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LAT_SPEC};

    rst_i = 1'b1; start_i = 1'b0; op_i = '0; rs1_i = '0; rs2_i = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_done", 32'(done_o), 32'd0);
    check("reset_result", result_o, 32'd0);

    // Abort a divide mid-iteration; it must never report completion.
    issue(3'd5, 32'd100, 32'd7, 32'd0, 0, 1'b0);
    repeat (10) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_done", 32'(done_o), 32'd0);
    check("abort_result", result_o, 32'd0);
    repeat (40) @(negedge clk_i);
    issue(3'd0, 32'd3, 32'd4, 32'd12, LAT_NORM, 1'b1);

    // Directed vectors with hand-derived expectations.
    for (int i = 0; i < 11; i++) begin
      issue(dir[i].op, dir[i].a, dir[i].b, dir[i].res, dir[i].lat, 1'b1);
    end

    // start_i held high with churning operands through CALC; the next accept
    // may only happen in the IDLE cycle following done_o.
    begin
      exp_t e;
      int n;
      wait_idle();
      op_i = 3'd4; rs1_i = 32'd1000; rs2_i = 32'hFFFF_FFFD; start_i = 1'b1;
      e.res = model(3'd4, 32'd1000, 32'hFFFF_FFFD);
      e.done_cyc = cyc + LAT_NORM;
      sb.push_back(e);
      n = 0;
      @(negedge clk_i);
      while (!done_o && n < 60) begin
        op_i = 3'($urandom_range(0, 7)); rs1_i = $urandom; rs2_i = $urandom;
        @(negedge clk_i);
        n++;
      end
      if (n >= 60) begin
        total++;
        bad++;
        $display("FAIL held_start_timeout: got done_o=0 expected pulse within 60 cycles");
      end
      op_i = 3'd3; rs1_i = 32'hDEAD_BEEF; rs2_i = 32'h1234_5678;
      e.res = model(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
      e.done_cyc = cyc + 1 + LAT_NORM;
      sb.push_back(e);
      repeat (2) @(negedge clk_i);
      start_i = 1'b0;
    end

    // Randomized requests against the reference model.
    for (int i = 0; i < 200; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      issue(op, a, b, model(op, a, b), latency(op, a, b), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end

    // Drain outstanding expectations.
    begin
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
        @(negedge clk_i);
        n++;
      end
      if (sb.size() != 0) begin
        total++;
        bad++;
        $display("FAIL drain: got %0d pending results expected 0", sb.size());
      end
    end
    wait_idle();
    check("final_busy", 32'(busy_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
